mult_div_unit: RTL

Iterative multiply/divide unit with architectural HI/LO registers for the 32-bit MIPS datapath. It sits directly downstream of the register file. Its operands are the register file's two read ports (rs → OperandA, rt → OperandB). It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the HI/LO results for MFHI/MFLO. While an iterative operation runs it asserts Busy, which the pipeline uses to stall.

---
 rtl/mult_div_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use one shift-add step per cycle and DIV/DIVU one restoring
// step per cycle. Both work on unsigned magnitudes, and the signs are fixed
// in a final FIX cycle. MTHI/MTLO write HI/LO directly from IDLE.
module mult_div_unit #(
    parameter int Width = 32
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [Width-1:0] OperandA,
    input  logic [Width-1:0] OperandB,
    output logic [Width-1:0] Hi,
    output logic [Width-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CntW = (Width > 1) ? $clog2(Width) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_t;

    state_t              state;
    logic [CntW-1:0]     count;

    // Datapath: {upper, lower} accumulator plus the multiplicand or divisor.
    logic [2*Width-1:0]  acc;
    logic [Width-1:0]    mcand;
    logic                is_div;
    logic                neg_q;
    logic                neg_r;
    logic                div_zero;

    logic                is_signed_op;
    logic                start_iter;
    logic                a_neg;
    logic                b_neg;
    logic [Width-1:0]    a_mag;
    logic [Width-1:0]    b_mag;
    logic [Width:0]      mul_sum;
    logic [2*Width-1:0]  mul_next;
    logic [Width:0]      div_shift;
    logic [Width:0]      div_trial;
    logic [2*Width-1:0]  div_next;
    logic [2*Width-1:0]  mul_res;
    logic [Width-1:0]    quot;
    logic [Width-1:0]    rem;
    logic [Width-1:0]    fix_hi;
    logic [Width-1:0]    fix_lo;

    // Operand magnitudes and result signs for a request starting this cycle.
    always_comb begin
        is_signed_op = (Op == OP_MULT) || (Op == OP_DIV);
        start_iter   = Start && (state == IDLE) && (Op[2] == 1'b0);
        a_neg        = is_signed_op && OperandA[Width-1];
        b_neg        = is_signed_op && OperandB[Width-1];
        a_mag        = a_neg ? -OperandA : OperandA;
        b_mag        = b_neg ? -OperandB : OperandB;
    end

    // One iteration step for each algorithm. The upper half of the
    // accumulator is the partial product or the running remainder.
    always_comb begin
        mul_sum   = {1'b0, acc[2*Width-1:Width]} + (acc[0] ? {1'b0, mcand} : '0);
        mul_next  = {mul_sum, acc[Width-1:1]};
        div_shift = acc[2*Width-1:Width-1];
        div_trial = div_shift - {1'b0, mcand};
        if (div_shift >= {1'b0, mcand})
            div_next = {div_trial[Width-1:0], acc[Width-2:0], 1'b1};
        else
            div_next = {div_shift[Width-1:0], acc[Width-2:0], 1'b0};
    end

    // Sign correction applied in FIX. For a zero divisor the remainder path
    // reproduces the original dividend, and the quotient is forced to all ones.
    always_comb begin
        mul_res = neg_q ? -acc : acc;
        quot    = acc[Width-1:0];
        rem     = acc[2*Width-1:Width];
        if (is_div) begin
            fix_hi = neg_r ? -rem : rem;
            fix_lo = div_zero ? '1 : (neg_q ? -quot : quot);
        end else begin
            fix_hi = mul_res[2*Width-1:Width];
            fix_lo = mul_res[Width-1:0];
        end
    end

    // Datapath registers: load on an accepted request, step once per RUN cycle.
    // NOTE: these registers are deliberately not reset; they are always
    // reloaded before use, and HI/LO never expose them outside FIX.
    always_ff @(posedge Clock) begin
        if (start_iter) begin
            is_div   <= Op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= Op[1] && a_neg;
            div_zero <= Op[1] && (OperandB == '0);
            if (Op[1]) begin
                acc   <= {{Width{1'b0}}, a_mag};
                mcand <= b_mag;
            end else begin
                acc   <= {{Width{1'b0}}, b_mag};
                mcand <= a_mag;
            end
        end else if (state == RUN) begin
            acc <= is_div ? div_next : mul_next;
        end
    end

    // Control FSM with registered HI/LO, Busy, Done and DivByZero.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state     <= IDLE;
            count     <= '0;
            Hi        <= '0;
            Lo        <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (Op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                count <= CntW'(Width - 1);
                                Busy  <= 1'b1;
                                state <= RUN;
                            end
                            OP_MTHI: begin
                                Hi   <= OperandA;
                                Done <= 1'b1;
                            end
                            OP_MTLO: begin
                                Lo   <= OperandA;
                                Done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (count == '0)
                        state <= FIX;
                    else
                        count <= count - 1'b1;
                end
                FIX: begin
                    Hi        <= fix_hi;
                    Lo        <= fix_lo;
                    Done      <= 1'b1;
                    DivByZero <= div_zero;
                    Busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
